sram_burst_initiator: RTL and testbench
=======================================

SRAM_BURST_INITIATOR -- requirements
Module: sram_burst_initiator

Interface
REQ-001 Parameter DATA_WIDTH, default 64: SRAM word and data-path width in bits.
REQ-002 Parameter NUM_WORDS, default 1024: SRAM depth; ADDR_WIDTH = $clog2(NUM_WORDS).
REQ-003 Parameter LOCK_ADDR, default 100: the write-once protected word address (used only under REQ-034).
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 cmd_valid_i / cmd_ready_o  in/out  1/1  burst command handshake.
REQ-007 cmd_we_i  in  1  1 = write burst, 0 = read burst.
REQ-008 cmd_addr_i  in  ADDR_WIDTH  burst start word address.
REQ-009 cmd_len_i  in  4  beats minus one (0 = 1 beat, 15 = 16 beats).
REQ-010 wdata_valid_i / wdata_ready_o  in/out  1/1  write-data beat handshake.
REQ-011 wdata_i  in  DATA_WIDTH  write-data beat.
REQ-012 rsp_valid_o / rsp_ready_i  out/in  1/1  read-response handshake.
REQ-013 rsp_rdata_o, rsp_last_o  out  DATA_WIDTH, 1  read-response data; last beat of burst flag.
REQ-014 req_o, we_o  out  1, 1  SRAM request and write enable.
REQ-015 addr_o, wdata_o, be_o  out  ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH  SRAM address, write data, per-bit enables.
REQ-016 rdata_i  in  DATA_WIDTH  SRAM read data, valid the cycle after a read request.
REQ-017 lock_err_o  out  1  sticky write-once violation flag.

Function
REQ-018 The FSM SHALL have states IDLE, WRITE, READ, DRAIN.
REQ-019 In IDLE, cmd_ready_o SHALL be 1; elsewhere it SHALL be 0.
REQ-020 On cmd_valid_i && cmd_ready_o: latch addr and len into cur_addr/beats_left; go to WRITE if cmd_we_i, else READ.
REQ-021 In WRITE, wdata_ready_o SHALL be 1; each accepted beat SHALL drive req_o=1, we_o=1, addr_o=cur_addr, wdata_o=wdata_i, be_o all ones in the same cycle.
REQ-022 Each beat (issued or not) SHALL increment cur_addr modulo NUM_WORDS (NUM_WORDS-1 wraps to 0) and decrement beats_left.
REQ-023 After the beat with beats_left==0, WRITE SHALL return to IDLE next cycle.
REQ-024 In READ, a read SHALL be issued (req_o=1, we_o=0, be_o=0) only when fifo_count + inflight - pop < 2.
REQ-025 A read issued in cycle N SHALL push rdata_i into a 2-entry response FIFO at the end of N+1; rsp_valid_o SHALL be high no earlier than N+2.
REQ-026 Each FIFO entry SHALL carry a last bit, set only for the final beat of the burst.
REQ-027 Simultaneous push and pop SHALL be supported; with rsp_ready_i held high, throughput SHALL be one beat per cycle.
REQ-028 After the last read is issued, READ SHALL go to DRAIN; DRAIN SHALL go to IDLE in the cycle after the last=1 response is popped.
REQ-029 The FIFO SHALL never overflow; rsp_rdata_o/rsp_last_o SHALL remain stable while rsp_valid_o && !rsp_ready_i.
REQ-030 Outside accepted beats, req_o SHALL be 0 and we_o, addr_o, wdata_o, be_o SHALL be 0.

Reset
REQ-031 Reset SHALL be asynchronous and active-low on rst_ni; assertion mid-burst SHALL abort the burst.
REQ-032 During reset: state=IDLE, FIFO empty, inflight=0, lock state cleared, all outputs 0 except cmd_ready_o.
REQ-033 cmd_ready_o SHALL be 1 from the first cycle after rst_ni deasserts.

Configuration
REQ-034 With SRAM_WRITE_ONCE_LOCK_EN defined: the first write beat to LOCK_ADDR SHALL issue normally and set lock_done. Later write beats to LOCK_ADDR SHALL be consumed (wdata_ready_o=1, address advances) with req_o=0. Each such beat SHALL set lock_err_o, which stays 1 until reset. Reads of LOCK_ADDR are unaffected.
REQ-035 Without SRAM_WRITE_ONCE_LOCK_EN: every write beat SHALL issue; lock_err_o SHALL be tied to 0; no lock state SHALL exist.

Verification
REQ-036 Write cmd addr=0x010 len=3, data 0xA0..0xA3 -> four consecutive req_o/we_o cycles, addr 0x010..0x013, then IDLE.
REQ-037 Read cmd addr=0x010 len=3, rsp_ready_i=1 -> rsp 0xA0..0xA3 back-to-back, rsp_last_o only on 0xA3, first rsp 2 cycles after first req_o.
REQ-038 Read len=7 with rsp_ready_i toggling 1/0 -> no lost or duplicated beats; data stable while stalled; req_o never issued with a full credit.
REQ-039 Write addr=0x3FE len=3 (NUM_WORDS=1024) -> addr_o sequence 0x3FE, 0x3FF, 0x000, 0x001.
REQ-040 With macro: two writes to 0x064 (0x11, then 0x22) -> second beat has req_o=0, lock_err_o=1, read of 0x064 returns 0x11; without macro: read returns 0x22, lock_err_o=0.
REQ-041 rst_ni low in READ with 2 responses buffered -> rsp_valid_o=0 and cmd_ready_o=1 immediately; a new command after release completes normally.

Source files
------------

// File: rtl/sram_burst_initiator.sv
// Burst command front-end for a single-port SRAM with a 2-entry read FIFO.
// Define SRAM_WRITE_ONCE_LOCK_EN to make LOCK_ADDR write-once.
module sram_burst_initiator #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 1024,
  parameter int LOCK_ADDR  = 100,
  localparam int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [3:0]            cmd_len_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_last_o,
  output logic                  req_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] be_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  lock_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [3:0]            beats_left;
  logic                  last_beat;
  logic                  inflight;
  logic                  inflight_last;

  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;

  logic                  wr_beat;
  logic                  wr_issue;
  logic                  rd_issue;
  logic                  blocked;
  logic                  pop;
  logic [2:0]            credit;

  assign cmd_ready_o   = (state == IDLE);
  assign wdata_ready_o = (state == WRITE);
  assign rsp_valid_o   = (fifo_count != 2'd0);
  assign rsp_rdata_o   = fifo_data[rd_ptr];
  assign rsp_last_o    = fifo_last[rd_ptr] & rsp_valid_o;

  assign pop       = rsp_valid_o & rsp_ready_i;
  assign last_beat = (beats_left == 4'd0);
  assign next_addr = (cur_addr == ADDR_WIDTH'(NUM_WORDS - 1))
                   ? '0 : cur_addr + 1'b1;

  // Reads not yet popped, counting the slot a same-cycle pop frees.
  assign credit   = {1'b0, fifo_count} + {2'b0, inflight}
                  - {2'b0, pop};
  assign rd_issue = (state == READ) && (credit < 3'd2);
  assign wr_beat  = (state == WRITE) && wdata_valid_i;
  assign wr_issue = wr_beat && !blocked;

`ifdef SRAM_WRITE_ONCE_LOCK_EN
  logic lock_done;
  logic lock_err;
  logic lock_hit;

  assign lock_hit   = wr_beat && (cur_addr == ADDR_WIDTH'(LOCK_ADDR));
  assign blocked    = lock_hit && lock_done;
  assign lock_err_o = lock_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_done <= 1'b0;
      lock_err  <= 1'b0;
    end else begin
      if (lock_hit) lock_done <= 1'b1;
      if (blocked)  lock_err  <= 1'b1;
    end
  end
`else
  assign blocked    = 1'b0;
  assign lock_err_o = 1'b0;
`endif

  always_comb begin
    req_o   = 1'b0;
    we_o    = 1'b0;
    addr_o  = '0;
    wdata_o = '0;
    be_o    = '0;
    unique case (1'b1)
      wr_issue: begin
        req_o   = 1'b1;
        we_o    = 1'b1;
        addr_o  = cur_addr;
        wdata_o = wdata_i;
        be_o    = '1;
      end
      rd_issue: begin
        req_o  = 1'b1;
        addr_o = cur_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      cur_addr      <= '0;
      beats_left    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_issue;
      inflight_last <= rd_issue && last_beat;
      unique case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            cur_addr   <= cmd_addr_i;
            beats_left <= cmd_len_i;
            state      <= cmd_we_i ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_beat) begin
            cur_addr   <= next_addr;
            beats_left <= beats_left - 4'd1;
            if (last_beat) state <= IDLE;
          end
        end
        READ: begin
          if (rd_issue) begin
            cur_addr   <= next_addr;
            beats_left <= beats_left - 4'd1;
            if (last_beat) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && rsp_last_o) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM data lands one cycle after the request, straight into the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_count   <= '0;
    end else begin
      if (inflight) begin
        fifo_data[wr_ptr] <= rdata_i;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_sram_burst_initiator.sv
// Randomized bench for sram_burst_initiator with a behavioural SRAM
// and an address/data scoreboard model.
module tb_sram_burst_initiator;
  localparam int DW = 64;
  localparam int NW = 1024;
  localparam int AW = 10;
  localparam int LA = 100;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_we_i = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [3:0]    cmd_len_i = '0;
  logic          wdata_valid_i = 1'b0;
  logic          wdata_ready_o;
  logic [DW-1:0] wdata_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_last_o;
  logic          req_o;
  logic          we_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic [DW-1:0] be_o;
  logic [DW-1:0] rdata_i;
  logic          lock_err_o;

  int total = 0;
  int bad = 0;
  bit lock_done_m = 0;
  bit lock_err_m = 0;
  logic [DW-1:0] ref_mem [NW];
  logic [DW-1:0] sram [NW];

  always #5 clk_i = ~clk_i;

  sram_burst_initiator dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i), .cmd_addr_i(cmd_addr_i),
    .cmd_len_i(cmd_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .wdata_i(wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_last_o(rsp_last_o),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .be_o(be_o), .rdata_i(rdata_i),
    .lock_err_o(lock_err_o)
  );

  initial begin
    for (int i = 0; i < NW; i++) sram[i] = '0;
    rdata_i = '0;
    forever begin
      @(posedge clk_i);
      if (req_o && !we_o) rdata_i <= sram[addr_o];
      if (req_o && we_o)
        sram[addr_o] = (sram[addr_o] & ~be_o) | (wdata_o & be_o);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic send_cmd(input bit w, input int a, input int l);
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_we_i = w;
    cmd_addr_i = AW'(a);
    cmd_len_i = 4'(l);
    #1;
    total++;
    if (cmd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL cmd_ready got=%b want=1", cmd_ready_o);
    end
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
  endtask

  task automatic do_write(input int a, input int l, input bit gaps,
                          input logic [DW-1:0] d [16]);
    int i = 0;
    int guard = 0;
    int ea;
    bit iss;
    logic [2*DW+AW+1:0] exp_v;
    send_cmd(1'b1, a, l);
    while (i <= l && guard < 200) begin
      @(negedge clk_i);
      guard++;
      wdata_valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      wdata_i = d[i];
      #1;
      total++;
      if (wdata_ready_o !== 1'b1) begin
        bad++;
        $display("FAIL wdata_ready got=%b want=1", wdata_ready_o);
      end
      ea = (a + i) % NW;
      if (wdata_valid_i) begin
        iss = 1;
`ifdef SRAM_WRITE_ONCE_LOCK_EN
        if (ea == LA) begin
          if (lock_done_m) begin
            iss = 0;
            lock_err_m = 1;
          end else lock_done_m = 1;
        end
`endif
        exp_v = iss ? {2'b11, AW'(ea), d[i], {DW{1'b1}}} : '0;
        total++;
        if ({req_o, we_o, addr_o, wdata_o, be_o} !== exp_v) begin
          bad++;
          $display("FAIL wr_beat %0d got=%h want=%h", i,
                   {req_o, we_o, addr_o, wdata_o, be_o}, exp_v);
        end
        if (iss) ref_mem[ea] = d[i];
        i++;
      end else begin
        total++;
        if (req_o !== 1'b0) begin
          bad++;
          $display("FAIL wr_idle_req got=%b want=0", req_o);
        end
      end
    end
    @(negedge clk_i);
    wdata_valid_i = 1'b0;
    #1;
    total++;
    if (guard >= 200 || cmd_ready_o !== 1'b1 || req_o !== 1'b0 ||
        lock_err_o !== lock_err_m) begin
      bad++;
      $display("FAIL wr_done rdy=%b req=%b err=%b want 1 0 %b",
               cmd_ready_o, req_o, lock_err_o, lock_err_m);
    end
  endtask

  task automatic do_read(input int a, input int l, input int mode);
    int issued = 0;
    int popped = 0;
    int guard = 0;
    int t = 0;
    int fi = -1;
    int fv = -1;
    int lp = -1;
    bit pn;
    bit stall = 0;
    logic [DW-1:0] pd = '0;
    logic pl = 1'b0;
    send_cmd(1'b0, a, l);
    while (popped <= l && guard < 300) begin
      @(negedge clk_i);
      guard++;
      t++;
      rsp_ready_i = (mode == 0) ? 1'b1 :
                    (mode == 1) ? t[0] : 1'($urandom_range(0, 1));
      #1;
      pn = rsp_valid_o && rsp_ready_i;
      if (stall) begin
        total++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== pd ||
            rsp_last_o !== pl) begin
          bad++;
          $display("FAIL rsp_stable got=%b/%h want=1/%h",
                   rsp_valid_o, rsp_rdata_o, pd);
        end
      end
      stall = rsp_valid_o && !rsp_ready_i;
      pd = rsp_rdata_o;
      pl = rsp_last_o;
      if (rsp_valid_o && fv < 0) fv = t;
      if (req_o) begin
        total++;
        if (we_o !== 1'b0 || be_o !== '0 ||
            addr_o !== AW'((a + issued) % NW) || issued > l ||
            (issued - popped - int'(pn)) >= 2) begin
          bad++;
          $display("FAIL rd_issue %0d addr=%h want=%h pend=%0d",
                   issued, addr_o, AW'((a + issued) % NW),
                   issued - popped - int'(pn));
        end
        if (fi < 0) fi = t;
        issued++;
      end
      if (pn) begin
        total++;
        if (rsp_rdata_o !== ref_mem[(a + popped) % NW] ||
            rsp_last_o !== (popped == l)) begin
          bad++;
          $display("FAIL rsp %0d got=%h/%b want=%h/%b", popped,
                   rsp_rdata_o, rsp_last_o,
                   ref_mem[(a + popped) % NW], popped == l);
        end
        popped++;
        lp = t;
      end
    end
    total++;
    if (guard >= 300 || fv - fi < 2 ||
        (mode == 0 && (fv - fi != 2 || lp - fi != l + 2))) begin
      bad++;
      $display("FAIL rd_timing lat=%0d span=%0d want 2 %0d",
               fv - fi, lp - fi, l + 2);
    end
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    #1;
    total++;
    if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rd_done rdy=%b val=%b want 1 0",
               cmd_ready_o, rsp_valid_o);
    end
  endtask

  task automatic test_reset;
    #2 rst_ni = 1'b0;
    @(negedge clk_i);
    #1;
    total++;
    if ({req_o, we_o, addr_o, wdata_o, be_o, rsp_valid_o, rsp_rdata_o,
         rsp_last_o, wdata_ready_o, lock_err_o} !== '0 ||
        cmd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_outputs req=%b val=%b rdy=%b",
               req_o, rsp_valid_o, cmd_ready_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    total++;
    if (cmd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_release rdy=%b want=1", cmd_ready_o);
    end
  endtask

  task automatic test_write_basic;
    logic [DW-1:0] d [16];
    for (int i = 0; i < 16; i++) d[i] = DW'(8'hA0 + i);
    do_write('h010, 3, 1'b0, d);
  endtask

  task automatic test_read_basic;
    do_read('h010, 3, 0);
  endtask

  task automatic test_read_stall;
    logic [DW-1:0] d [16];
    for (int i = 0; i < 16; i++) d[i] = {$urandom, $urandom};
    do_write('h020, 7, 1'b1, d);
    do_read('h020, 7, 1);
  endtask

  task automatic test_wrap;
    logic [DW-1:0] d [16];
    for (int i = 0; i < 16; i++) d[i] = {$urandom, $urandom};
    do_write('h3FE, 3, 1'b1, d);
    do_read('h3FE, 3, 2);
  endtask

  task automatic test_reset_mid_read;
    rsp_ready_i = 1'b0;
    send_cmd(1'b0, 'h020, 7);
    repeat (5) @(negedge clk_i);
    #1;
    total++;
    if (rsp_valid_o !== 1'b1 || req_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_read_full val=%b req=%b want 1 0",
               rsp_valid_o, req_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b0;
    lock_done_m = 0;
    lock_err_m = 0;
    #1;
    total++;
    if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 ||
        req_o !== 1'b0 || lock_err_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_read_reset val=%b rdy=%b want 0 1",
               rsp_valid_o, cmd_ready_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    do_read('h020, 7, 0);
  endtask

  task automatic test_lock;
    logic [DW-1:0] d [16];
    for (int i = 0; i < 16; i++) d[i] = '0;
    d[0] = DW'(8'h11);
    do_write(LA, 0, 1'b0, d);
    d[0] = DW'(8'h22);
    do_write(LA, 0, 1'b0, d);
    do_read(LA, 0, 0);
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] d [16];
    int a;
    int l;
    for (int n = 0; n < 24; n++) begin
      a = $urandom_range(0, NW - 1);
      l = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) d[i] = {$urandom, $urandom};
        do_write(a, l, 1'b1, d);
      end else begin
        do_read(a, l, 2);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_read_stall();
    test_wrap();
    test_reset_mid_read();
    test_lock();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
